imm_gen_pipe: RTL and testbench

- Parametrised, registered immediate generator for the decode stage. Sits between fetch/instruction buffer and the register-read/execute stage.
- Classifies each instruction by opcode and emits one selected, sign-extended immediate of width XLEN, its format code and an illegal flag.
- Results are buffered in a DEPTH-entry output FIFO with valid/ready handshakes on both sides.

---
 rtl/imm_pkg.sv | 53 +++++
 rtl/imm_sel.sv | 116 +++++++++++
 rtl/imm_gen_pipe.sv | 80 ++++++++
 tb/tb_imm_gen_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants and the FIFO entry type for the decode-stage immediate generator.
package imm_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_C   = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  localparam logic [1:0] RVC_Q0 = 2'b00;
  localparam logic [1:0] RVC_Q1 = 2'b01;
  localparam logic [1:0] RVC_Q2 = 2'b10;

  localparam logic [2:0] C0_ADDI4SPN = 3'b000;
  localparam logic [2:0] C0_LW       = 3'b010;
  localparam logic [2:0] C0_SW       = 3'b110;
  localparam logic [2:0] C1_ADDI     = 3'b000;
  localparam logic [2:0] C1_JAL      = 3'b001;
  localparam logic [2:0] C1_LI       = 3'b010;
  localparam logic [2:0] C1_LUI      = 3'b011;
  localparam logic [2:0] C1_J        = 3'b101;
  localparam logic [2:0] C1_BEQZ     = 3'b110;
  localparam logic [2:0] C1_BNEZ     = 3'b111;
  localparam logic [2:0] C2_LWSP     = 3'b010;
  localparam logic [2:0] C2_SWSP     = 3'b110;

  // imm is held at the widest XLEN; narrower builds use the low bits.
  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    logic [2:0]          fmt;
    logic                illegal;
    logic [31:0]         instr;
  } imm_entry_t;

endpackage

// File: rtl/imm_sel.sv
// Combinational opcode classifier and immediate builder.
// IMM_GEN_RVC_EN enables 16-bit compressed decode; otherwise compressed words are ILL.
module imm_sel import imm_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0] instr,
  output imm_entry_t  ent
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [63:0] sx;
  logic [63:0] i_imm, s_imm, b_imm, u_imm, j_imm, shamt;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign sx    = {64{instr[31]}};
  assign i_imm = {sx[63:12], instr[31:20]};
  assign s_imm = {sx[63:12], instr[31:25], instr[11:7]};
  assign b_imm = {sx[63:12], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {sx[63:32], instr[31:12], 12'b0};
  assign j_imm = {sx[63:20], instr[19:12], instr[20], instr[30:21], 1'b0};
  // funct7 / arithmetic-shift bit is not part of the shift amount
  assign shamt = IS64 ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};

`ifdef IMM_GEN_RVC_EN
  logic [15:0] c;
  logic [63:0] csx;
  logic [63:0] c_addi4spn, c_lsw, c_ci, c_lui, c_16sp, c_jmp, c_br, c_lwsp, c_swsp;
  logic        rv_ok;
  logic [63:0] rv_imm;

  assign c          = instr[15:0];
  assign csx        = {64{c[12]}};
  assign c_addi4spn = {54'b0, c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign c_lsw      = {57'b0, c[5], c[12:10], c[6], 2'b00};
  assign c_ci       = {csx[63:5], c[6:2]};
  assign c_lui      = {csx[63:17], c[6:2], 12'b0};
  assign c_16sp     = {csx[63:9], c[4:3], c[5], c[2], c[6], 4'b0};
  assign c_jmp      = {csx[63:11], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
  assign c_br       = {csx[63:8], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
  assign c_lwsp     = {56'b0, c[3:2], c[12], c[6:4], 2'b00};
  assign c_swsp     = {56'b0, c[8:7], c[12:9], 2'b00};

  always_comb begin
    rv_ok  = 1'b0;
    rv_imm = '0;
    case (c[1:0])
      RVC_Q0: case (c[15:13])
        C0_ADDI4SPN:  begin rv_imm = c_addi4spn; rv_ok = (c_addi4spn != '0); end
        C0_LW, C0_SW: begin rv_imm = c_lsw;      rv_ok = 1'b1; end
        default: ;
      endcase
      RVC_Q1: case (c[15:13])
        C1_ADDI, C1_LI:   begin rv_imm = c_ci;  rv_ok = 1'b1; end
        C1_JAL:           begin rv_imm = c_jmp; rv_ok = !IS64; end
        C1_J:             begin rv_imm = c_jmp; rv_ok = 1'b1; end
        C1_BEQZ, C1_BNEZ: begin rv_imm = c_br;  rv_ok = 1'b1; end
        C1_LUI: begin
          // rd=x2 selects C.ADDI16SP; a zero immediate is reserved in both forms
          if (c[11:7] == 5'd2) begin rv_imm = c_16sp; rv_ok = (c_16sp != '0); end
          else                 begin rv_imm = c_lui;  rv_ok = (c_lui  != '0); end
        end
        default: ;
      endcase
      RVC_Q2: case (c[15:13])
        C2_LWSP: begin rv_imm = c_lwsp; rv_ok = 1'b1; end
        C2_SWSP: begin rv_imm = c_swsp; rv_ok = 1'b1; end
        default: ;
      endcase
      default: ;
    endcase
  end
`endif

  always_comb begin
    ent.imm     = '0;
    ent.fmt     = FMT_ILL;
    ent.illegal = 1'b1;
    ent.instr   = instr;
    if (instr[1:0] == 2'b11) begin
      ent.illegal = 1'b0;
      case (opc)
        OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin ent.fmt = FMT_I; ent.imm = i_imm; end
        OPC_OPIMM: begin
          ent.fmt = FMT_I;
          ent.imm = (f3 == 3'b001 || f3 == 3'b101) ? shamt : i_imm;
        end
        OPC_STORE:            begin ent.fmt = FMT_S; ent.imm = s_imm; end
        OPC_BRANCH:           begin ent.fmt = FMT_B; ent.imm = b_imm; end
        OPC_LUI, OPC_AUIPC:   begin ent.fmt = FMT_U; ent.imm = u_imm; end
        OPC_JAL:              begin ent.fmt = FMT_J; ent.imm = j_imm; end
        OPC_OP:               ent.fmt = FMT_R;
        OPC_OPIMM32: begin
          if (IS64) begin ent.fmt = FMT_I; ent.imm = i_imm; end
          else ent.illegal = 1'b1;
        end
        OPC_OP32: begin
          if (IS64) ent.fmt = FMT_R;
          else      ent.illegal = 1'b1;
        end
        default: ent.illegal = 1'b1;
      endcase
    end
`ifdef IMM_GEN_RVC_EN
    else if (rv_ok) begin
      ent.fmt     = FMT_C;
      ent.illegal = 1'b0;
      ent.imm     = rv_imm;
    end
`endif
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: imm_sel decode feeding a DEPTH-entry output FIFO.
// Optional compressed decode via IMM_GEN_RVC_EN (see imm_sel).
module imm_gen_pipe import imm_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [31:0]     out_instr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("imm_gen_pipe: DEPTH must be a power of two in 2..8");
  end

  imm_entry_t [DEPTH-1:0] mem;
  imm_entry_t             ent_new, head;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   push, pop;
  logic                   unused_imm;

  imm_sel #(.XLEN(XLEN)) u_sel (
    .instr (in_instr),
    .ent   (ent_new)
  );

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ent_new;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head        = out_valid ? mem[rd_ptr] : '0;
  assign out_imm     = head.imm[XLEN-1:0];
  assign out_fmt     = head.fmt;
  assign out_illegal = head.illegal;
  assign out_instr   = head.instr;
  assign unused_imm  = ^head.imm;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe (XLEN=32, DEPTH=2) with a queue-based reference model.
module tb_imm_gen_pipe;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0]     in_instr, out_instr;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;

  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
    logic [31:0]     instr;
  } exp_t;

  exp_t q[$];

  imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t obs();
    exp_t o;
    o = {out_imm, out_fmt, out_illegal, out_instr};
    return o;
  endfunction

  // Reference decoder: immediates assembled with signed arithmetic from the ISA field rules.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t   e;
    longint v;
    longint sw;
    sw = longint'($signed(w));
    v = 0;
    e.fmt = 3'd7; e.ill = 1'b1; e.instr = w;
    if (w[1:0] == 2'b11) begin
      e.ill = 1'b0;
      case (w[6:0])
        7'h03, 7'h67, 7'h73: begin e.fmt = 3'd1; v = sw >>> 20; end
        7'h13: begin
          e.fmt = 3'd1;
          if (w[14:12] == 3'b001 || w[14:12] == 3'b101) v = longint'(w[24:20]);
          else v = sw >>> 20;
        end
        7'h23: begin e.fmt = 3'd2; v = (sw >>> 25) * 32 + longint'(w[11:7]); end
        7'h63: begin
          e.fmt = 3'd3;
          v = (w[31] ? -64'sd4096 : 64'sd0) + longint'(w[7]) * 2048
              + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        end
        7'h37, 7'h17: begin e.fmt = 3'd4; v = (sw >>> 12) * 4096; end
        7'h6F: begin
          e.fmt = 3'd5;
          v = (w[31] ? -64'sd1048576 : 64'sd0) + longint'(w[19:12]) * 4096
              + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        end
        7'h33: e.fmt = 3'd0;
        default: begin e.fmt = 3'd7; e.ill = 1'b1; end
      endcase
    end
    e.imm = v[XLEN-1:0];
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  ops [12];
    logic [31:0] w;
    int          r;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h1B, 7'h3B};
    w = $urandom;
    r = $urandom_range(0, 15);
    if (r < 12) w[6:0] = ops[r];
    else if (r < 14) w[1:0] = 2'b11;
`ifdef IMM_GEN_RVC_EN
    else w[1:0] = 2'b11;
`else
    else w[1:0] = 2'($urandom_range(0, 2));
`endif
    return w;
  endfunction

  task automatic test_reset();
    exp_t z;
    z = '0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    nvec++; if (obs() !== z) begin nerr++; $display("FAIL reset_fields: got %h want %h", obs(), z); end
  endtask

  task automatic test_directed();
    logic [31:0] wi [6];
    logic [31:0] wimm [6];
    logic [2:0]  wfmt [6];
    logic        will [6];
    exp_t        e;
    wi   = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h001000EF, 32'h4050D093, 32'h0000007F};
    wimm = '{32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC, 32'h00000800, 32'h00000005, 32'h00000000};
    wfmt = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd7};
    will = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_instr = wi[i];
      tick();
      e = {wimm[i], wfmt[i], will[i], wi[i]};
      nvec++; if (out_valid !== 1'b1 || obs() !== e) begin
        nerr++; $display("FAIL directed_%0d: got v=%b %h want %h", i, out_valid, obs(), e);
      end
    end
    in_valid = 1'b0;
    tick();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL directed_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, c;
    exp_t ea, eb, ec;
    a = gen_instr(); b = gen_instr(); c = gen_instr();
    ea = ref_decode(a); eb = ref_decode(b); ec = ref_decode(c);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = a;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready_empty: got %b want 1", in_ready); end
    tick();
    in_instr = b;
    nvec++; if (in_ready !== 1'b1 || obs() !== ea) begin nerr++; $display("FAIL bp_one: got r=%b %h want r=1 %h", in_ready, obs(), ea); end
    tick();
    in_instr = c;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
    tick();
    nvec++; if (in_ready !== 1'b0 || obs() !== ea) begin nerr++; $display("FAIL bp_held: got r=%b %h want r=0 %h", in_ready, obs(), ea); end
    out_ready = 1'b1;
    tick();
    nvec++; if (in_ready !== 1'b1 || obs() !== eb) begin nerr++; $display("FAIL bp_drain_b: got r=%b %h want r=1 %h", in_ready, obs(), eb); end
    tick();
    in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || obs() !== ec) begin
      nerr++; $display("FAIL bp_pushpop_c: got v=%b r=%b %h want v=1 r=1 %h", out_valid, in_ready, obs(), ec);
    end
    tick();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    logic [31:0] e_w;
    exp_t ee, z;
    z = '0;
    e_w = gen_instr(); ee = ref_decode(e_w);
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = gen_instr(); tick();
    in_instr = gen_instr(); tick();
    in_instr = 32'h00500093; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs() !== z) begin
      nerr++; $display("FAIL flush_full: got v=%b r=%b %h want v=0 r=1 0", out_valid, in_ready, obs());
    end
    tick();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_dropped: got %b want 0", out_valid); end
    in_valid = 1'b1; in_instr = e_w; tick();
    nvec++; if (obs() !== ee) begin nerr++; $display("FAIL flush_after: got %h want %h", obs(), ee); end
    // one entry buffered, so without flush this input would be accepted
    in_instr = gen_instr(); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; tick();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_partial: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    exp_t z;
    z = '0;
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = gen_instr(); tick();
    in_instr = gen_instr(); tick();
    rst = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs() !== z) begin
      nerr++; $display("FAIL reset_mid: got v=%b r=%b %h want v=0 r=1 0", out_valid, in_ready, obs());
    end
  endtask

  task automatic test_rvc();
    exp_t e;
`ifdef IMM_GEN_RVC_EN
    e = {32'hFFFFFFFF, 3'd6, 1'b0, 32'h000050FD};
`else
    e = {32'h0, 3'd7, 1'b1, 32'h000050FD};
`endif
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h000050FD; tick();
    nvec++; if (obs() !== e) begin nerr++; $display("FAIL rvc_cli: got %h want %h", obs(), e); end
    // all-zero halfword is the reserved C.ADDI4SPN form
    e = {32'h0, 3'd7, 1'b1, 32'h0};
    in_instr = 32'h0; tick();
    nvec++; if (obs() !== e) begin nerr++; $display("FAIL rvc_zero: got %h want %h", obs(), e); end
    // RV64-only opcode is illegal at XLEN=32
    e = {32'h0, 3'd7, 1'b1, 32'h0010809B};
    in_instr = 32'h0010809B; tick();
    nvec++; if (obs() !== e) begin nerr++; $display("FAIL rv64_opc: got %h want %h", obs(), e); end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_random();
    bit   m_ready, m_valid;
    exp_t z, e;
    z = '0;
    q.delete();
    for (int i = 0; i < 500; i++) begin
      flush     = ($urandom_range(0, 31) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_instr  = gen_instr();
      out_ready = ($urandom_range(0, 3) != 0);
      m_ready   = (q.size() < DEPTH);
      m_valid   = (q.size() > 0);
      e = m_valid ? q[0] : z;
      nvec++; if (in_ready !== m_ready || out_valid !== m_valid || obs() !== e) begin
        nerr++; $display("FAIL random_%0d: got v=%b r=%b %h want v=%b r=%b %h",
                         i, out_valid, in_ready, obs(), m_valid, m_ready, e);
      end
      if (flush) q.delete();
      else begin
        if (m_valid && out_ready) void'(q.pop_front());
        if (in_valid && m_ready) q.push_back(ref_decode(in_instr));
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_rvc();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
